// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX -> EX -> EX/MEM signal bundle for the EX stage.
//   slave  modport: used by ex_stage (consumes ID/EX fields, drives EX/MEM fields).
//   master modport: used by the surrounding pipeline (drives ID/EX, observes EX/MEM).
// Inputs : WB_i, M_i, ALUSrc_i, ALUOp_i, RegDst_i, RegData1_i, RegData2_i, SignExt_i,
//          RegAddrRt_i, RegAddrRd_i, ForwardA_i, ForwardB_i, MemWbData_i
// Outputs: WB_o, M_o, ALUResult_o, WriteData_o, RegAddrW_o, Stall_o, Busy_o
//          (+ Overflow_o when EX_OVERFLOW_EN is defined)
interface ex_stage_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [1:0]            WB_i;
    logic [1:0]            M_i;
    logic                  ALUSrc_i;
    logic [1:0]            ALUOp_i;
    logic                  RegDst_i;
    logic [DATA_WIDTH-1:0] RegData1_i;
    logic [DATA_WIDTH-1:0] RegData2_i;
    logic [DATA_WIDTH-1:0] SignExt_i;
    logic [4:0]            RegAddrRt_i;
    logic [4:0]            RegAddrRd_i;
    logic [1:0]            ForwardA_i;
    logic [1:0]            ForwardB_i;
    logic [DATA_WIDTH-1:0] MemWbData_i;
    logic [1:0]            WB_o;
    logic [1:0]            M_o;
    logic [DATA_WIDTH-1:0] ALUResult_o;
    logic [DATA_WIDTH-1:0] WriteData_o;
    logic [4:0]            RegAddrW_o;
    logic                  Stall_o;
    logic                  Busy_o;
`ifdef EX_OVERFLOW_EN
    logic                  Overflow_o;
`endif

    modport slave (
        input  WB_i, M_i, ALUSrc_i, ALUOp_i, RegDst_i, RegData1_i, RegData2_i, SignExt_i,
        input  RegAddrRt_i, RegAddrRd_i, ForwardA_i, ForwardB_i, MemWbData_i,
`ifdef EX_OVERFLOW_EN
        output Overflow_o,
`endif
        output WB_o, M_o, ALUResult_o, WriteData_o, RegAddrW_o, Stall_o, Busy_o
    );

    modport master (
        output WB_i, M_i, ALUSrc_i, ALUOp_i, RegDst_i, RegData1_i, RegData2_i, SignExt_i,
        output RegAddrRt_i, RegAddrRd_i, ForwardA_i, ForwardB_i, MemWbData_i,
`ifdef EX_OVERFLOW_EN
        input  Overflow_o,
`endif
        input  WB_o, M_o, ALUResult_o, WriteData_o, RegAddrW_o, Stall_o, Busy_o
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: pipeline EX stage. Operand forwarding, single-cycle ALU, iterative shift-add
// multiplier (funct 011000) and the EX/MEM boundary registers.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-low reset
//   bus    - ex_stage_if.slave bundle (ID/EX fields in, EX/MEM fields + Stall/Busy out)
// Optional feature: define EX_OVERFLOW_EN to add a registered signed-overflow flag
// (Overflow_o) that also suppresses the register write of an overflowing add/sub.
module ex_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MUL_STEP   = 1
) (
    input logic         clk_i,
    input logic         rst_i,
    ex_stage_if.slave   bus
);
    localparam int unsigned N     = DATA_WIDTH / MUL_STEP;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned MSB   = DATA_WIDTH - 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] fwd_a, fwd_b, op_b, sum, diff, alu_res, partial;
    logic [5:0]            funct;
    logic [4:0]            dest;
    logic                  is_mul, is_add, is_sub, stall;

    // EX/MEM registers
    logic [1:0]            wb_q, m_q;
    logic [DATA_WIDTH-1:0] res_q, wdata_q;
    logic [4:0]            waddr_q;
    logic                  busy_q;
    // Multiplier state, latched at first presentation of the MUL
    logic [DATA_WIDTH-1:0] mcand_q, mplier_q, acc_q, fb_lat_q;
    logic [1:0]            wb_lat_q, m_lat_q;
    logic [4:0]            dest_lat_q;
    logic [CNT_W-1:0]      cnt_q;

    assign funct  = bus.SignExt_i[5:0];
    assign is_mul = (bus.ALUOp_i == 2'b10) && (funct == 6'b011000);
    assign dest   = bus.RegDst_i ? bus.RegAddrRd_i : bus.RegAddrRt_i;

    always_comb begin
        case (bus.ForwardA_i)
            2'b10:   fwd_a = res_q;
            2'b01:   fwd_a = bus.MemWbData_i;
            default: fwd_a = bus.RegData1_i;
        endcase
        case (bus.ForwardB_i)
            2'b10:   fwd_b = res_q;
            2'b01:   fwd_b = bus.MemWbData_i;
            default: fwd_b = bus.RegData2_i;
        endcase
    end

    assign op_b = bus.ALUSrc_i ? bus.SignExt_i : fwd_b;
    assign sum  = fwd_a + op_b;
    assign diff = fwd_a - op_b;

    always_comb begin
        alu_res = '0;
        is_add  = 1'b0;
        is_sub  = 1'b0;
        unique case (bus.ALUOp_i)
            2'b00: begin alu_res = sum;  is_add = 1'b1; end
            2'b01: begin alu_res = diff; is_sub = 1'b1; end
            2'b11: alu_res = fwd_a | op_b;
            2'b10: begin
                case (funct)
                    6'b100000: begin alu_res = sum;  is_add = 1'b1; end
                    6'b100010: begin alu_res = diff; is_sub = 1'b1; end
                    6'b100100: alu_res = fwd_a & op_b;
                    6'b100101: alu_res = fwd_a | op_b;
                    6'b101010: alu_res = DATA_WIDTH'($signed(fwd_a) < $signed(op_b));
                    default:   alu_res = '0;
                endcase
            end
        endcase
    end

`ifdef EX_OVERFLOW_EN
    logic ovf, ovf_q;
    // Signed overflow: result sign disagrees with what the operand signs allow.
    assign ovf = (is_add && (fwd_a[MSB] == op_b[MSB]) && (sum[MSB] != fwd_a[MSB])) ||
                 (is_sub && (fwd_a[MSB] != op_b[MSB]) && (diff[MSB] != fwd_a[MSB]));
`endif

    // Partial product for MUL_STEP multiplier bits, built from shifted multiplicands.
    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (is_mul) state_d = StBusy;
            StBusy:  if (cnt_q == CNT_W'(N - 1)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        stall = 1'b0;
        case (state_q)
            StIdle:  stall = is_mul;
            StBusy:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wb_q       <= '0;
            m_q        <= '0;
            res_q      <= '0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            busy_q     <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            fb_lat_q   <= '0;
            wb_lat_q   <= '0;
            m_lat_q    <= '0;
            dest_lat_q <= '0;
            cnt_q      <= '0;
`ifdef EX_OVERFLOW_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (is_mul) begin
                        // Bubble into EX/MEM; data fields keep their old values.
                        wb_q       <= '0;
                        m_q        <= '0;
                        mcand_q    <= fwd_a;
                        mplier_q   <= fwd_b;
                        fb_lat_q   <= fwd_b;
                        wb_lat_q   <= bus.WB_i;
                        m_lat_q    <= bus.M_i;
                        dest_lat_q <= dest;
                        acc_q      <= '0;
                        cnt_q      <= '0;
`ifdef EX_OVERFLOW_EN
                        ovf_q      <= 1'b0;
`endif
                    end else begin
`ifdef EX_OVERFLOW_EN
                        wb_q       <= ovf ? 2'b00 : bus.WB_i;
                        ovf_q      <= ovf;
`else
                        wb_q       <= bus.WB_i;
`endif
                        m_q        <= bus.M_i;
                        res_q      <= alu_res;
                        wdata_q    <= fwd_b;
                        waddr_q    <= dest;
                    end
                end
                StBusy: begin
                    wb_q     <= '0;
                    m_q      <= '0;
                    acc_q    <= acc_q + partial;
                    mplier_q <= mplier_q >> MUL_STEP;
                    mcand_q  <= mcand_q << MUL_STEP;
                    cnt_q    <= cnt_q + 1'b1;
                end
                StDone: begin
                    wb_q    <= wb_lat_q;
                    m_q     <= m_lat_q;
                    res_q   <= acc_q;
                    wdata_q <= fb_lat_q;
                    waddr_q <= dest_lat_q;
`ifdef EX_OVERFLOW_EN
                    ovf_q   <= 1'b0;
`endif
                end
                default: ;
            endcase
            busy_q <= (state_d == StBusy);
        end
    end

    assign bus.WB_o        = wb_q;
    assign bus.M_o         = m_q;
    assign bus.ALUResult_o = res_q;
    assign bus.WriteData_o = wdata_q;
    assign bus.RegAddrW_o  = waddr_q;
    assign bus.Stall_o     = stall;
    assign bus.Busy_o      = busy_q;
`ifdef EX_OVERFLOW_EN
    assign bus.Overflow_o  = ovf_q;
`endif
endmodule
